// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit to 16-bit SRAM bridge.
//   state_t         : controller FSM states
//   SRAM_BASE_DEF   : default byte address of data-memory word 0
//   SRAM_DW/SRAM_AW : external SRAM data and half-word address widths
//   SRAM_IDX_W      : width of the 32-bit word index inside the SRAM
package sram_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [31:0] SRAM_BASE_DEF = 32'd1024;
  localparam int          SRAM_DW       = 16;
  localparam int          SRAM_AW       = 18;
  localparam int          SRAM_IDX_W    = SRAM_AW - 1;

endpackage

// File: rtl/sram_controller.sv
// Bridges the MEM stage's 32-bit data-memory port to a 16-bit async SRAM.
// Each access is split into a low half-word cycle, a high half-word cycle,
// WAIT_CYCLES settle cycles and one DONE cycle; ready stays low until DONE
// so the upstream pipeline is frozen for 3+WAIT_CYCLES cycles.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   wr_en      : store request (level, held while ready=0)
//   rd_en      : load request  (level, held while ready=0)
//   address    : byte address of the access
//   write_data : store value
//   read_data  : load result, valid while ready=1 after a read
//   ready      : 0 = freeze pipeline, 1 = access complete or no access
//   sram_dq    : bidirectional SRAM data bus, driven only while writing
//   sram_addr  : SRAM half-word address
//   sram_we_n  : SRAM write enable, active-low
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] SRAM_BASE   = SRAM_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  inout  wire  [SRAM_DW-1:0]   sram_dq,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic                 sram_we_n
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  op_wr_q;
  logic [31:0]           rdata_q;
  logic [SRAM_AW-1:0]    addr_q;
  logic                  we_n_q;
  logic [SRAM_IDX_W-1:0] idx;
  logic                  req;

  assign req = rd_en | wr_en;
  // Word index wraps modulo 2^17; the discarded upper bits never reach the SRAM.
  assign idx = SRAM_IDX_W'((address - SRAM_BASE) >> 2);

  // Outputs for each half-access are registered on the edge that enters
  // that cycle, so address and write strobe are clean for the whole cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      rdata_q <= 32'd0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_LOW;
            op_wr_q <= wr_en;           // write wins when both are requested
            addr_q  <= {idx, 1'b0};
            we_n_q  <= ~wr_en;
          end
        end
        ST_LOW: begin
          if (!op_wr_q) rdata_q[15:0] <= sram_dq;
          state_q <= ST_HIGH;
          addr_q  <= {idx, 1'b1};
          we_n_q  <= ~op_wr_q;
        end
        ST_HIGH: begin
          if (!op_wr_q) rdata_q[31:16] <= sram_dq;
          state_q <= ST_WAIT;
          we_n_q  <= 1'b1;
          cnt_q   <= WAIT_INIT;
        end
        ST_WAIT: begin
          // Counter was loaded with WAIT_CYCLES, so this state lasts exactly that long.
          if (cnt_q <= 4'd1) begin
            state_q <= ST_DONE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The bus is driven exactly while the write strobe is active, so reset
  // releases it at the same instant it deasserts sram_we_n.
  assign sram_dq   = (!we_n_q) ? ((state_q == ST_HIGH) ? write_data[31:16] : write_data[15:0])
                               : {SRAM_DW{1'bz}};
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign read_data = rdata_q;
  assign ready     = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .SRAM_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n)
  );

  // Behavioural async SRAM: combinational read whenever not writing,
  // write of the bus value at the end of each write-strobe cycle.
  logic [15:0] sram_model [0:(1<<18)-1];
  assign sram_dq = sram_we_n ? sram_model[sram_addr] : 16'bz;
  always @(posedge clk) if (!sram_we_n) sram_model[sram_addr] <= sram_dq;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory: 32-bit words keyed by word index, unwritten words read 0.
  logic [31:0] mem_ref [int unsigned];
  logic [31:0] last_rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Measures one access from its IDLE cycle (cycle 0) to the ready cycle.
  task automatic monitor(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int unsigned start_c, output int unsigned end_c);
    int unsigned off, idx, wc;
    int          done;
    logic [17:0] a1, a2;
    logic [15:0] q1, q2;
    logic [31:0] exp;
    off = a - BASE;
    idx = (off / 4) % 131072;
    wc = 0; done = -1; a1 = '0; a2 = '0; q1 = '0; q2 = '0;
    start_c = cyc;
    end_c = cyc;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 1) begin a1 = sram_addr; q1 = sram_dq; end
      if (c == 2) begin a2 = sram_addr; q2 = sram_dq; end
      if (!sram_we_n) wc++;
      if (ready) begin done = c; end_c = cyc; break; end
    end
    chk("latency", 32'(done), 32'(3 + W));
    chk("we_pulses", wc, w ? 32'd2 : 32'd0);
    chk("addr_lo", 32'(a1), idx * 2);
    chk("addr_hi", 32'(a2), idx * 2 + 1);
    if (w) begin
      chk("dq_lo", 32'(q1), 32'(d[15:0]));
      chk("dq_hi", 32'(q2), 32'(d[31:16]));
      chk("rdata_hold", read_data, last_rd);
      mem_ref[idx] = d;
    end else begin
      exp = mem_ref.exists(idx) ? mem_ref[idx] : 32'd0;
      chk("rdata", read_data, exp);
      last_rd = exp;
    end
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output int unsigned s, output int unsigned e);
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d;
    monitor(w, a, d, s, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_we_n", 32'(sram_we_n), 32'd1);
    end
  endtask

  initial begin
    int unsigned s0, e0, s1, e1;
    logic [31:0] a, d;
    logic        w, r;
    for (int i = 0; i < (1 << 18); i++) sram_model[i] = 16'h0000;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    last_rd = 32'd0;

    // Reset values
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    idle(4);

    // Directed store/load pairs
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, s0, e0);
    idle(1);
    access(1'b0, 1'b1, 32'd1024, 32'h0, s0, e0);
    chk("load_deadbeef", read_data, 32'hDEADBEEF);
    idle(1);
    access(1'b1, 1'b0, 32'd1028, 32'h12345678, s0, e0);
    access(1'b0, 1'b1, 32'd1028, 32'h0, s1, e1);
    chk("load_12345678", read_data, 32'h12345678);
    chk("b2b_span", e1 - s0 + 1, 32'd12);
    idle(1);
    access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, s0, e0);
    access(1'b0, 1'b1, 32'd1032, 32'h0, s0, e0);
    chk("load_a5a5", read_data, 32'hA5A55A5A);
    idle(1);

    // Reset asserted during the HIGH cycle of a store
    d = $urandom;
    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1036; write_data = d;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_rdata", read_data, 32'd0);
    last_rd = 32'd0;
    @(posedge clk); #1 rst = 1'b1;
    monitor(1'b1, 32'd1036, d, s0, e0);
    access(1'b0, 1'b1, 32'd1036, 32'h0, s0, e0);
    idle(1);

    // Randomized traffic, including addresses that wrap the word index
    for (int k = 0; k < 24; k++) begin
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      access(w, r, a, d, s0, e0);
      if ($urandom_range(0, 1) == 1) idle(32'($urandom_range(1, 2)));
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the MEM stage's 32-bit data-memory port to a 16-bit external asynchronous SRAM. Each load or store becomes two 16-bit SRAM accesses plus a fixed settle interval. While an access is in progress the controller drops `ready`, and the top level uses that to freeze every pipeline register upstream of the MEM stage register. It replaces the single-cycle data memory inside MEM_Stage and sits directly downstream of it.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: settle cycles after the second half-access (legal range 1–15).
- `SRAM_BASE`, default 1024: byte address of data-memory word 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: store request from MEM stage, level.
- `rd_en` in 1: load request from MEM stage, level.
- `address` in 32: byte address (the ALU result).
- `write_data` in 32: store value (the Rm value).
- `read_data` out 32: load result, valid while `ready`=1 after a read.
- `ready` out 1: 0 = freeze the pipeline; 1 = the MEM-stage access is complete or there is no access.
- `sram_dq` inout 16: SRAM data bus, high-Z unless writing.
- `sram_addr` out 18: SRAM half-word address.
- `sram_we_n` out 1: SRAM write enable, active-low.

## Operation
- Address map:
  - word index = (`address` − `SRAM_BASE`)[18:2], 17 bits; upper bits are discarded, so the address wraps modulo 2^17 words.
  - low half at `sram_addr` = {idx,0}; high half at {idx,1}.
- FSM states: IDLE, LOW, HIGH, WAIT, DONE.
  - IDLE → LOW when `rd_en`|`wr_en`; the operation type is latched at this edge.
  - If both are asserted, write wins.
  - LOW → HIGH → WAIT, unconditionally.
  - WAIT holds for `WAIT_CYCLES` cycles (4-bit down-counter), then → DONE.
  - DONE → IDLE unconditionally.
- LOW cycle:
  - `sram_addr`={idx,0}.
  - Write: `sram_dq`=`write_data`[15:0], `sram_we_n`=0.
  - Read: `read_data`[15:0] is captured from `sram_dq` at the closing edge.
- HIGH cycle: same as LOW with {idx,1} and bits [31:16].
- WAIT and DONE: `sram_we_n`=1, `sram_dq` high-Z, `sram_addr` holds the last value.
- `ready` is combinational:
  - 1 in DONE.
  - 1 in IDLE when there is no request.
  - 0 otherwise.
- `address`, `write_data`, `rd_en` and `wr_en` are stable while `ready`=0, because the pipeline is frozen. The controller latches only the operation type.
- Back-to-back: the request present in the cycle after DONE starts a fresh access from IDLE.
- Reset (`rst`=0), asynchronous and also mid-access:
  - state=IDLE, counter=0.
  - `read_data`=0, `sram_we_n`=1, `sram_dq` high-Z, `sram_addr`=0.
  - `ready` = !(`rd_en`|`wr_en`).
  - An aborted write may leave the SRAM half-written. This is accepted.

## Timing
- Request first visible in cycle 0 (IDLE).
- LOW is cycle 1 and HIGH is cycle 2.
- WAIT occupies cycles 3 … 2+`WAIT_CYCLES`.
- DONE (`ready`=1) falls in cycle 3+`WAIT_CYCLES`, which is 5 with the default.
- Pipeline freeze length = 3+`WAIT_CYCLES` cycles per memory instruction.
- `read_data` is final from cycle 3 onward and holds until the next read's LOW edge.
- `sram_we_n` is low for exactly 2 cycles per store, on the LOW and HIGH cycles.

## Structure
- A shared package holds:
  - the state enum (IDLE/LOW/HIGH/WAIT/DONE);
  - the `SRAM_BASE` default;
  - the SRAM width constants (data 16, address 18).
- No sub-module. The FSM, counter and tri-state driver live in one module.
- The bench supplies a behavioural 2^18×16 async SRAM model, named sram_model, with combinational read.

## Test plan
- Idle, `rd_en`=`wr_en`=0 → `ready`=1 continuously; `sram_we_n`=1; `sram_dq` high-Z.
- Store 0xDEADBEEF to 1024 → two write cycles:
  - cycle 1: `sram_addr`=0, `sram_dq`=0xBEEF, `we_n`=0;
  - cycle 2: `sram_addr`=1, `sram_dq`=0xDEAD, `we_n`=0;
  - `ready`=1 only in cycle 5.
- Load from 1024 after that store → `read_data`=0xDEADBEEF with `ready`=1 in cycle 5; no `we_n` pulse.
- Store 0x12345678 to 1028, then load 1028 the next cycle after DONE → addresses 2/3 are used; read returns 0x12345678; the total span is 12 cycles.
- `rd_en`=`wr_en`=1 at 1032 with `write_data`=0xA5A5_5A5A → treated as a store (`we_n` pulses); a following load returns 0xA5A55A5A.
- `rst` driven low in cycle 2 of a store → state IDLE immediately; `we_n`=1 and `dq` high-Z in the same cycle. After release the retried request completes in 5 cycles.
